// File: rtl/sk6812_frame_ctrl.sv
// SK6812 frame sequencer: fetches pixels, serialises them MSB-first
// into the bit encoder, then holds the latch gap. Option: SK6812_BIT_TIMEOUT_EN
module sk6812_frame_ctrl #(
  parameter int BITS_PER_PIXEL = 32,
  parameter int PIX_CNT_W      = 10,
  parameter int RESET_CYCLES   = 16000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 Rst_n,
  input  logic                 start,
  input  logic [PIX_CNT_W-1:0] num_pixels,
  input  logic [31:0]          pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 enc_bit,
  output logic                 enc_le,
  input  logic                 enc_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
);

  localparam int MSB = BITS_PER_PIXEL - 1;
  localparam int BW  = $clog2(BITS_PER_PIXEL + 1);
  localparam int GW  = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [PIX_CNT_W-1:0] pix_left;
  logic [BW-1:0]        bit_left;
  logic [MSB:0]         shreg;
  logic [GW-1:0]        gap_cnt;
  logic                 accept;
  logic                 shift;
  logic                 timeout;
  logic                 unused_hi;

  assign accept    = (state == S_FETCH) && pix_valid;
  assign shift     = (state == S_WAIT) && enc_done;
  assign unused_hi = ^pix_data;

`ifdef SK6812_BIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign timeout = (state == S_WAIT) && !enc_done &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  // Watchdog restarts on every entry into WAIT.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT) ? wd_cnt + TW'(1) : '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      pix_left <= '0;
      bit_left <= '0;
      shreg    <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) pix_left <= num_pixels;
      if (accept) begin
        shreg    <= pix_data[MSB:0];
        bit_left <= BW'(BITS_PER_PIXEL);
        pix_left <= pix_left - PIX_CNT_W'(1);
      end
      if (shift) begin
        shreg    <= shreg << 1;
        bit_left <= bit_left - BW'(1);
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  always_comb begin
    state_nx   = state;
    pix_ready  = 1'b0;
    enc_le     = 1'b0;
    enc_bit    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = (num_pixels == '0) ? S_GAP : S_FETCH;
      end
      S_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_nx = S_SEND;
      end
      S_SEND: begin
        enc_le   = 1'b1;
        enc_bit  = shreg[MSB];
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Bit stays stable for the encoder's delayed sample.
        enc_bit = shreg[MSB];
        if (enc_done) begin
          if (bit_left != BW'(1))   state_nx = S_SEND;
          else if (pix_left != '0)  state_nx = S_FETCH;
          else                      state_nx = S_GAP;
        end else if (timeout) begin
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(RESET_CYCLES)) state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sk6812_frame_ctrl.sv
// Bench for sk6812_frame_ctrl: 24-bit and 32-bit instances,
// encoder/pixel-source models, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_sk6812_frame_ctrl;

  localparam int RC = 200;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_s, pv_s, ed_s;
  logic [1:0] rdy_s, bit_s, le_s, busy_s, fd_s, err_s;
  logic [9:0] num_s [2];
  logic [31:0] pd_s [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sk6812_frame_ctrl #(
    .BITS_PER_PIXEL(24), .PIX_CNT_W(10),
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) u24 (
    .clk(clk), .Rst_n(rst_n), .start(start_s[0]),
    .num_pixels(num_s[0]), .pix_data(pd_s[0]),
    .pix_valid(pv_s[0]), .pix_ready(rdy_s[0]),
    .enc_bit(bit_s[0]), .enc_le(le_s[0]),
    .enc_done(ed_s[0]), .busy(busy_s[0]),
    .frame_done(fd_s[0]), .err(err_s[0])
  );

  sk6812_frame_ctrl #(
    .BITS_PER_PIXEL(32), .PIX_CNT_W(10),
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) u32 (
    .clk(clk), .Rst_n(rst_n), .start(start_s[1]),
    .num_pixels(num_s[1]), .pix_data(pd_s[1]),
    .pix_valid(pv_s[1]), .pix_ready(rdy_s[1]),
    .enc_bit(bit_s[1]), .enc_le(le_s[1]),
    .enc_done(ed_s[1]), .busy(busy_s[1]),
    .frame_done(fd_s[1]), .err(err_s[1])
  );

  // control-owned configuration
  logic [31:0] pix [2][3];
  int stall_len [2];
  int supp [2];

  // model-owned observations
  int le_cnt [2], rdy_cnt [2], done_cnt [2];
  int hold_err [2], lat_err [2], ovl_err [2];
  int idx [2], sc [2], gave [2], ecnt [2];
  int start_cyc [2], first_rdy [2], done_cyc [2];
  int le_cyc [2], err_cyc [2], acc_cyc [2];
  logic [127:0] bits_log [2];
  logic [1:0] cur_bit, pbusy, perr;

  // pixel source + encoder model, sampled 1 ns after each edge
  initial begin
    pv_s = '0;
    ed_s = '0;
    pbusy = '0;
    perr = '0;
    cur_bit = '0;
    for (int g = 0; g < 2; g++) begin
      pd_s[g] = '0;
      le_cnt[g] = 0; rdy_cnt[g] = 0; done_cnt[g] = 0;
      hold_err[g] = 0; lat_err[g] = 0; ovl_err[g] = 0;
      idx[g] = 0; sc[g] = 0; gave[g] = 0; ecnt[g] = 0;
      start_cyc[g] = 0; first_rdy[g] = -1; done_cyc[g] = 0;
      le_cyc[g] = 0; err_cyc[g] = 0; acc_cyc[g] = -10;
      bits_log[g] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (start_s[g] && !pbusy[g] && rst_n) begin
          idx[g] = 0;
          sc[g] = stall_len[g];
          gave[g] = 0;
          start_cyc[g] = cyc - 1;
          first_rdy[g] = -1;
        end
        if (acc_cyc[g] == cyc - 1 && !le_s[g]) lat_err[g]++;
        if (rdy_s[g]) begin
          rdy_cnt[g]++;
          if (first_rdy[g] < 0) first_rdy[g] = cyc;
          if (le_s[g]) ovl_err[g]++;
        end
        if (rdy_s[g] && idx[g] == 1 && sc[g] > 0) begin
          pv_s[g] = 1'b0;
          sc[g]--;
        end else if (rdy_s[g] && idx[g] < 3) begin
          pv_s[g] = 1'b1;
          pd_s[g] = pix[g][idx[g]];
          idx[g]++;
          acc_cyc[g] = cyc;
        end else begin
          pv_s[g] = 1'b0;
        end
        ed_s[g] = 1'b0;
        if (le_s[g]) begin
          le_cnt[g]++;
          bits_log[g] = {bits_log[g][126:0], bit_s[g]};
          cur_bit[g] = bit_s[g];
          ecnt[g] = 3;
          le_cyc[g] = cyc;
        end else if (ecnt[g] > 0) begin
          if (busy_s[g] && bit_s[g] != cur_bit[g]) hold_err[g]++;
          ecnt[g]--;
          if (ecnt[g] == 0 && (supp[g] < 0 || gave[g] < supp[g])) begin
            ed_s[g] = 1'b1;
            gave[g]++;
          end
        end
        if (fd_s[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        if (err_s[g] && !perr[g]) err_cyc[g] = cyc;
        pbusy[g] = busy_s[g];
        perr[g] = err_s[g];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_bits(input string nm, input logic [127:0] act,
                          input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input int g, input int n);
    @(negedge clk);
    start_s[g] = 1'b1;
    num_s[g] = 10'(n);
    @(negedge clk);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int d0, input string nm);
    int k;
    k = 0;
    while (done_cnt[g] == d0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt[g] == d0) begin
      errors++;
      $display("FAIL %s frame_done timeout actual none required pulse", nm);
    end
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    int g;
    int n;
    logic [31:0] p0, p1, p2;
    int stall;
    int exp_le;
    int exp_rdy;
    logic [127:0] exp_bits;
  } vec_t;

  vec_t vt [4];
  int le0, rdy0, d0, e0;
  logic [127:0] mask;

  initial begin
    vt[0] = '{0, 1, 32'h00A50F3C, 32'h0, 32'h0, 0, 24, 1,
              128'hA50F3C};
    vt[1] = '{1, 3, 32'hDEADBEEF, 32'h12345678, 32'h80000001, 50, 96, 53,
              128'hDEADBEEF_12345678_80000001};
    vt[2] = '{0, 2, 32'hFFFFFFFF, 32'hAB000001, 32'h0, 3, 48, 5,
              128'hFFFFFF_000001};
    vt[3] = '{1, 1, 32'h00000000, 32'h0, 32'h0, 0, 32, 1, 128'h0};

    rst_n = 1'b0;
    start_s = '0;
    for (int g = 0; g < 2; g++) begin
      num_s[g] = '0;
      stall_len[g] = 0;
      supp[g] = -1;
      for (int j = 0; j < 3; j++) pix[g][j] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {rdy_s, le_s, bit_s, busy_s, fd_s, err_s}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      pix[vt[i].g][0] = vt[i].p0;
      pix[vt[i].g][1] = vt[i].p1;
      pix[vt[i].g][2] = vt[i].p2;
      stall_len[vt[i].g] = vt[i].stall;
      le0 = le_cnt[vt[i].g];
      rdy0 = rdy_cnt[vt[i].g];
      d0 = done_cnt[vt[i].g];
      e0 = hold_err[vt[i].g] + lat_err[vt[i].g] + ovl_err[vt[i].g];
      pulse_start(vt[i].g, vt[i].n);
      wait_done(vt[i].g, d0, $sformatf("v%0d", i));
      chk($sformatf("v%0d_le", i), le_cnt[vt[i].g] - le0, vt[i].exp_le);
      chk($sformatf("v%0d_rdy", i), rdy_cnt[vt[i].g] - rdy0, vt[i].exp_rdy);
      chk($sformatf("v%0d_done", i), done_cnt[vt[i].g] - d0, 1);
      mask = (128'(1) << vt[i].exp_le) - 128'(1);
      chk_bits($sformatf("v%0d_bits", i), bits_log[vt[i].g] & mask,
               vt[i].exp_bits);
      chk($sformatf("v%0d_timing", i),
          hold_err[vt[i].g] + lat_err[vt[i].g] + ovl_err[vt[i].g] - e0, 0);
      chk($sformatf("v%0d_rdy_lat", i),
          first_rdy[vt[i].g] - start_cyc[vt[i].g], 1);
      chk($sformatf("v%0d_idle", i), busy_s[vt[i].g], 0);
    end

    le0 = le_cnt[1];
    rdy0 = rdy_cnt[1];
    d0 = done_cnt[1];
    pulse_start(1, 0);
    wait_done(1, d0, "zero");
    chk("zero_le", le_cnt[1] - le0, 0);
    chk("zero_rdy", rdy_cnt[1] - rdy0, 0);
    chk("zero_done_lat", done_cyc[1] - start_cyc[1], RC + 2);

    pix[1][0] = 32'h0F0F0F0F;
    stall_len[1] = 0;
    le0 = le_cnt[1];
    rdy0 = rdy_cnt[1];
    d0 = done_cnt[1];
    pulse_start(1, 1);
    repeat (10) @(negedge clk);
    pulse_start(1, 3);
    wait_done(1, d0, "rebusy");
    chk("rebusy_le", le_cnt[1] - le0, 32);
    chk("rebusy_rdy", rdy_cnt[1] - rdy0, 1);
    chk("rebusy_done", done_cnt[1] - d0, 1);
    chk_bits("rebusy_bits", bits_log[1] & 128'hFFFFFFFF, 128'h0F0F0F0F);

    pix[1][0] = 32'hCAFEF00D;
    pix[1][1] = 32'h55555555;
    d0 = done_cnt[1];
    pulse_start(1, 2);
    for (int k = 0; k < 200 && !le_s[1]; k++) @(negedge clk);
    chk("rstmid_le_seen", le_s[1], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_outs", {rdy_s, le_s, bit_s, busy_s, fd_s, err_s}, 0);
    repeat (3) @(negedge clk);
    chk("rstmid_hold", {rdy_s, le_s, bit_s, busy_s, fd_s, err_s}, 0);
    rst_n = 1'b1;
    repeat (RC + 50) @(negedge clk);
    chk("rstmid_no_done", done_cnt[1] - d0, 0);
    chk("rstmid_idle", busy_s[1], 0);

`ifdef SK6812_BIT_TIMEOUT_EN
    pix[1][0] = 32'hAAAAAAAA;
    pix[1][1] = 32'hAAAAAAAA;
    supp[1] = 5;
    le0 = le_cnt[1];
    d0 = done_cnt[1];
    pulse_start(1, 2);
    wait_done(1, d0, "tmo");
    chk("tmo_le", le_cnt[1] - le0, 6);
    chk("tmo_err_lat", err_cyc[1] - (le_cyc[1] + 1), TO);
    chk("tmo_done", done_cnt[1] - d0, 1);
    chk("tmo_err_sticky", err_s[1], 1);
    supp[1] = -1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("tmo_err_clr", err_s[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`else
    chk("err_tied", err_s, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
